// File: rtl/blinkt_led_serial_rx.sv
// APA102/Blinkt serial link receiver: synchronises serial_clk/serial_data, finds the
// 32-zero start frame and decodes NUM_LEDS 32-bit LED words onto a valid/ready port.
module blinkt_led_serial_rx #(
   parameter int NUM_LEDS     = 8,
   parameter int IDX_W        = 3,
   parameter int SYNC_STAGES  = 2,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             serial_clk,
   input  logic             serial_data,
   output logic             led_valid,
   input  logic             led_ready,
   output logic [IDX_W-1:0] led_index,
   output logic [4:0]       led_brightness,
   output logic [7:0]       led_blue,
   output logic [7:0]       led_green,
   output logic [7:0]       led_red,
   output logic             frame_start,
   output logic             frame_done,
   output logic             frame_error,
   output logic             overrun
);

   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [1:0] {HUNT, ARMED, WORD, ARMED_NEXT} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, sdat_sync;
   logic                   sclk_dly, edge_q, bit_q;

   // Edge strobe and its data bit are registered together so they stay aligned.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sclk_sync <= '0;
         sdat_sync <= '0;
         sclk_dly  <= 1'b0;
         edge_q    <= 1'b0;
         bit_q     <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], serial_clk};
         sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], serial_data};
         sclk_dly  <= sclk_sync[SYNC_STAGES-1];
         edge_q    <= sclk_sync[SYNC_STAGES-1] & ~sclk_dly;
         bit_q     <= sdat_sync[SYNC_STAGES-1];
      end
   end

   state_t            state_q, state_d;
   logic [5:0]        zero_q, zero_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [30:0]       shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  hidx_q, hidx_d;
   logic [4:0]        bri_q, bri_d;
   logic [7:0]        blu_q, blu_d, grn_q, grn_d, red_q, red_d;
   logic              start_q, start_d, done_q, done_d, err_q, err_d, ovr_q, ovr_d;
   logic [31:0]       word;
   logic              accept;

   assign word   = {shift_q, bit_q};
   assign accept = valid_q & led_ready;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= HUNT;
         zero_q  <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         idx_q   <= '0;
         idle_q  <= '0;
         valid_q <= 1'b0;
         hidx_q  <= '0;
         bri_q   <= '0;
         blu_q   <= '0;
         grn_q   <= '0;
         red_q   <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         idle_q  <= idle_d;
         valid_q <= valid_d;
         hidx_q  <= hidx_d;
         bri_q   <= bri_d;
         blu_q   <= blu_d;
         grn_q   <= grn_d;
         red_q   <= red_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      idle_d  = idle_q;
      valid_d = valid_q & ~accept;
      hidx_d  = hidx_q;
      bri_d   = bri_q;
      blu_d   = blu_q;
      grn_d   = grn_q;
      red_d   = red_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ovr_d   = 1'b0;

      case (state_q)
         HUNT: begin
            if (edge_q) begin
               if (bit_q) begin
                  zero_d = '0;
               end else if (zero_q == 6'd31) begin
                  zero_d  = 6'd32;
                  state_d = ARMED;
                  start_d = 1'b1;
                  idx_d   = '0;
               end else begin
                  zero_d = zero_q + 6'd1;
               end
            end
         end

         ARMED: begin
            if (edge_q && bit_q) begin
               shift_d = 31'd1;
               cnt_d   = 6'd1;
               idle_d  = '0;
               state_d = WORD;
            end
         end

         ARMED_NEXT: begin
            if (edge_q) begin
               shift_d = {30'd0, bit_q};
               cnt_d   = 6'd1;
               idle_d  = '0;
               state_d = WORD;
            end else if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = HUNT;
               zero_d  = '0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end

         WORD: begin
            if (edge_q) begin
               idle_d  = '0;
               shift_d = word[30:0];
               cnt_d   = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  cnt_d = '0;
                  // An all-zero word is a fresh start frame arriving mid-stream.
                  if (word == 32'd0) begin
                     start_d = 1'b1;
                     idx_d   = '0;
                     state_d = ARMED;
                  end else if (word[31:29] == 3'b111) begin
                     if (!valid_q || accept) begin
                        valid_d = 1'b1;
                        hidx_d  = idx_q;
                        bri_d   = word[28:24];
                        blu_d   = word[23:16];
                        grn_d   = word[15:8];
                        red_d   = word[7:0];
                     end else begin
                        ovr_d = 1'b1;
                     end
                     if (idx_q == IDX_W'(NUM_LEDS - 1)) begin
                        done_d  = 1'b1;
                        state_d = HUNT;
                        zero_d  = '0;
                     end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ARMED_NEXT;
                     end
                  end else begin
                     err_d   = 1'b1;
                     state_d = HUNT;
                     zero_d  = '0;
                  end
               end
            end else if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = HUNT;
               zero_d  = '0;
               cnt_d   = '0;
               idle_d  = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end

         default: state_d = HUNT;
      endcase
   end

   assign led_valid      = valid_q;
   assign led_index      = hidx_q;
   assign led_brightness = bri_q;
   assign led_blue       = blu_q;
   assign led_green      = grn_q;
   assign led_red        = red_q;
   assign frame_start    = start_q;
   assign frame_done     = done_q;
   assign frame_error    = err_q;
   assign overrun        = ovr_q;

endmodule

// File: tb/tb_blinkt_led_serial_rx.sv
// Directed bench for blinkt_led_serial_rx: word-level model of the link protocol
// feeds an expected-beat queue and pulse counts that a per-cycle monitor checks.
module tb_blinkt_led_serial_rx;

   localparam int NUM_LEDS     = 8;
   localparam int IDX_W        = 3;
   localparam int SYNC_STAGES  = 2;
   localparam int IDLE_TIMEOUT = 1024;
   localparam int HALF         = 5;
   localparam int LAT          = SYNC_STAGES + 2;

   logic             clk_clk = 1'b0;
   logic             reset_reset_n = 1'b0;
   logic             serial_clk = 1'b0;
   logic             serial_data = 1'b0;
   logic             led_ready = 1'b1;
   logic             led_valid;
   logic [IDX_W-1:0] led_index;
   logic [4:0]       led_brightness;
   logic [7:0]       led_blue, led_green, led_red;
   logic             frame_start, frame_done, frame_error, overrun;

   blinkt_led_serial_rx #(
      .NUM_LEDS(NUM_LEDS), .IDX_W(IDX_W), .SYNC_STAGES(SYNC_STAGES), .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .serial_clk(serial_clk), .serial_data(serial_data),
      .led_valid(led_valid), .led_ready(led_ready), .led_index(led_index),
      .led_brightness(led_brightness), .led_blue(led_blue), .led_green(led_green),
      .led_red(led_red), .frame_start(frame_start), .frame_done(frame_done),
      .frame_error(frame_error), .overrun(overrun)
   );

   always #5 clk_clk = ~clk_clk;

   int n_cmp = 0, n_bad = 0;
   int cycle = 0, last_rise = 0;
   int cnt_start = 0, cnt_done = 0, cnt_err = 0, cnt_ovr = 0, beats_seen = 0;
   int exp_start = 0, exp_done = 0, exp_err = 0, exp_ovr = 0;
   logic        timeout_mode = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] last_beat = '0;
   logic [31:0] cur;
   logic [31:0] prev_fields = '0;
   logic        prev_valid = 1'b0, prev_ready = 1'b0;

   logic        m_in_frame = 1'b0, m_held = 1'b0;
   int          m_idx = 0;

   always @(posedge clk_clk) cycle <= cycle + 1;

   assign cur = {led_index, led_brightness, led_blue, led_green, led_red};

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic apply_bit(input logic b);
      serial_data = b;
      repeat (HALF) tick();
      serial_clk = 1'b1;
      last_rise  = cycle;
      repeat (HALF) tick();
      serial_clk = 1'b0;
   endtask

   // Protocol model: what one complete 32-bit word must produce on the outputs.
   task automatic model_word(input logic [31:0] w);
      if (!m_in_frame) return;
      if (w == 32'd0) begin
         exp_start++;
         m_idx = 0;
      end else if (w[31:29] != 3'b111) begin
         exp_err++;
         m_in_frame = 1'b0;
      end else begin
         if (m_held) exp_ovr++;
         else begin
            exp_q.push_back({3'(m_idx), w[28:0]});
            if (!led_ready) m_held = 1'b1;
         end
         if (m_idx == NUM_LEDS - 1) begin
            exp_done++;
            m_in_frame = 1'b0;
         end else m_idx++;
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] w, input logic modelled);
      for (int i = 31; i >= 1; i--) apply_bit(w[i]);
      if (modelled) model_word(w);
      apply_bit(w[0]);
   endtask

   task automatic send_start(input int nzeros);
      for (int i = 0; i < 31; i++) apply_bit(1'b0);
      exp_start++;
      m_in_frame = 1'b1;
      m_idx = 0;
      for (int i = 31; i < nzeros; i++) apply_bit(1'b0);
   endtask

   task automatic send_frame(input int nzeros, input int nwords, input int bad_at);
      send_start(nzeros);
      for (int i = 0; i < nwords; i++)
         apply_stimulus((i == bad_at) ? 32'h6FFF_FFFF : 32'hE110_2030 + 32'(i), 1'b1);
   endtask

   task automatic end_test(input string name);
      repeat (30) tick();
      check_output({name, "_starts"}, 32'(cnt_start), 32'(exp_start));
      check_output({name, "_dones"}, 32'(cnt_done), 32'(exp_done));
      check_output({name, "_errors"}, 32'(cnt_err), 32'(exp_err));
      check_output({name, "_overruns"}, 32'(cnt_ovr), 32'(exp_ovr));
      check_output({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Per-cycle monitor: handshake, hold stability, event latency and coincidence rules.
   always @(negedge clk_clk) begin
      if (reset_reset_n) begin
         if (prev_valid && !prev_ready) begin
            check_output("hold_valid", 32'(led_valid), 32'd1);
            check_output("hold_fields", cur, prev_fields);
         end
         if (led_valid && !prev_valid)
            check_output("valid_latency", 32'(cycle - last_rise), 32'(LAT));
         if (led_valid && led_ready) begin
            beats_seen <= beats_seen + 1;
            last_beat  <= cur;
            if (exp_q.size() == 0) check_output("unexpected_beat", cur, 32'hFFFF_FFFF);
            else check_output("beat", cur, exp_q.pop_front());
         end
         if (frame_start) begin
            cnt_start <= cnt_start + 1;
            check_output("start_latency", 32'(cycle - last_rise), 32'(LAT));
         end
         if (frame_done) begin
            cnt_done <= cnt_done + 1;
            check_output("done_latency", 32'(cycle - last_rise), 32'(LAT));
            check_output("done_with_load", 32'((led_valid && !prev_valid &&
                         led_index == IDX_W'(NUM_LEDS - 1)) || overrun), 32'd1);
         end
         if (frame_error) begin
            cnt_err <= cnt_err + 1;
            check_output("error_latency", 32'(cycle - last_rise),
                         32'(timeout_mode ? LAT + IDLE_TIMEOUT : LAT));
            check_output("error_no_load", 32'(led_valid && !prev_valid), 32'd0);
         end
         if (overrun) begin
            cnt_ovr <= cnt_ovr + 1;
            check_output("overrun_latency", 32'(cycle - last_rise), 32'(LAT));
         end
      end
      prev_valid  <= led_valid;
      prev_ready  <= led_ready;
      prev_fields <= cur;
   end

   int b0, o0;

   initial begin
      repeat (4) tick();
      check_output("reset_outputs", 32'({led_valid, frame_start, frame_done, frame_error,
                   overrun}), 32'd0);
      check_output("reset_fields", cur, 32'd0);
      reset_reset_n = 1'b1;
      repeat (4) tick();

      // Plain frame, consumer always ready.
      b0 = beats_seen;
      send_frame(32, NUM_LEDS, -1);
      end_test("t1");
      check_output("t1_beat_count", 32'(beats_seen - b0), 32'd8);
      check_output("t1_last_beat", last_beat, {3'd7, 5'd1, 8'h10, 8'h20, 8'h37});
      check_output("t1_one_start", 32'(cnt_start), 32'd1);

      // Extra start padding and a trailing all-ones end frame.
      b0 = beats_seen;
      send_frame(40, NUM_LEDS, -1);
      apply_stimulus(32'hFFFF_FFFF, 1'b1);
      end_test("t2");
      check_output("t2_beat_count", 32'(beats_seen - b0), 32'd8);
      check_output("t2_no_error", 32'(cnt_err), 32'd0);

      // Bad header on word 3; rest of that frame is ignored, next frame recovers.
      b0 = beats_seen;
      send_frame(32, NUM_LEDS, 3);
      end_test("t3a");
      check_output("t3_beats_before_error", 32'(beats_seen - b0), 32'd3);
      b0 = beats_seen;
      send_frame(32, NUM_LEDS, -1);
      end_test("t3b");
      check_output("t3_recovered_beats", 32'(beats_seen - b0), 32'd8);

      // Consumer stalled for a whole frame.
      led_ready = 1'b0;
      o0 = cnt_ovr;
      b0 = beats_seen;
      send_frame(32, NUM_LEDS, -1);
      repeat (30) tick();
      check_output("t4_held_word", cur, {3'd0, 5'd1, 8'h10, 8'h20, 8'h30});
      check_output("t4_held_valid", 32'(led_valid), 32'd1);
      check_output("t4_overruns", 32'(cnt_ovr - o0), 32'd7);
      led_ready = 1'b1;
      m_held = 1'b0;
      repeat (3) tick();
      check_output("t4_drained", 32'(led_valid), 32'd0);
      end_test("t4");
      check_output("t4_one_transfer", 32'(beats_seen - b0), 32'd1);

      // serial_clk stops after 17 bits of word 2.
      b0 = beats_seen;
      send_frame(32, 2, -1);
      for (int i = 31; i >= 15; i--) apply_bit(1'b1);
      timeout_mode = 1'b1;
      exp_err++;
      m_in_frame = 1'b0;
      repeat (IDLE_TIMEOUT + 20) tick();
      timeout_mode = 1'b0;
      end_test("t5a");
      check_output("t5_beats", 32'(beats_seen - b0), 32'd2);
      send_frame(32, NUM_LEDS, -1);
      end_test("t5b");

      // Reset in the middle of word 5, then a full frame.
      send_frame(32, 5, -1);
      for (int i = 31; i >= 15; i--) apply_bit(1'b1);
      repeat (2) tick();
      reset_reset_n = 1'b0;
      repeat (5) tick();
      check_output("t6_reset_outputs", 32'({led_valid, frame_start, frame_done, frame_error,
                   overrun}), 32'd0);
      check_output("t6_reset_fields", cur, 32'd0);
      exp_q.delete();
      m_in_frame = 1'b0;
      m_held = 1'b0;
      reset_reset_n = 1'b1;
      repeat (5) tick();
      b0 = beats_seen;
      send_frame(32, NUM_LEDS, -1);
      end_test("t6");
      check_output("t6_beat_count", 32'(beats_seen - b0), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
